// File: rtl/ticket_sale_ctrl.sv
// ticket_sale_ctrl: transaction sequencer for the ticket vending machine.
// Latches a ticket selection, accumulates inserted coins, arbitrates
// confirm/cancel, dispenses one ticket pulse per ticket, computes change and
// holds the result on the display outputs before returning to idle.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-low
//   type_in      requested ticket type (1..4)
//   count_in     requested ticket count (1..MAX_COUNT)
//   sel_valid    pulse: latch type_in/count_in
//   coin1/5/10   pulses: 1, 5 and 10 yuan coins
//   confirm      pulse: purchase request
//   cancel       pulse: abort request
//   money        accumulated inserted money (binary)
//   moneyReturn  change or refund amount (binary)
//   ticketType   latched ticket type
//   ticketCount  latched ticket count
//   ticket_pulse one pulse per ticket dispensed
//   coin_reject  pulse: coin(s) refused
//   busy         high in every state except idle
//   state        current FSM state (debug)
module ticket_sale_ctrl #(
    parameter logic [7:0]  PRICE1      = 8'd2,
    parameter logic [7:0]  PRICE2      = 8'd3,
    parameter logic [7:0]  PRICE3      = 8'd4,
    parameter logic [7:0]  PRICE4      = 8'd5,
    parameter logic [2:0]  MAX_COUNT   = 3'd4,
    parameter logic [7:0]  MONEY_MAX   = 8'd99,
    parameter logic [31:0] HOLD_CYCLES = 32'd200_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] type_in,
    input  logic [2:0] count_in,
    input  logic       sel_valid,
    input  logic       coin1,
    input  logic       coin5,
    input  logic       coin10,
    input  logic       confirm,
    input  logic       cancel,
    output logic [7:0] money,
    output logic [7:0] moneyReturn,
    output logic [2:0] ticketType,
    output logic [2:0] ticketCount,
    output logic       ticket_pulse,
    output logic       coin_reject,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPay      = 3'd1,
        StDispense = 3'd2,
        StDone     = 3'd3
    } state_t;

    state_t      st_q;
    logic [2:0]  disp_cnt_q;
    logic [31:0] hold_cnt_q;

    logic [7:0] price;
    logic [7:0] total;
    logic [4:0] coin_sum;
    logic [8:0] money_sum;
    logic       coin_any;
    logic       coin_fits;
    logic [7:0] money_upd;
    logic       sel_ok;

    assign state = st_q;
    assign busy  = (st_q != StIdle);

    always_comb begin
        price = 8'd0;
        case (ticketType)
            3'd1:    price = PRICE1;
            3'd2:    price = PRICE2;
            3'd3:    price = PRICE3;
            3'd4:    price = PRICE4;
            default: price = 8'd0;
        endcase
    end

    assign total     = price * {5'd0, ticketCount};
    assign coin_sum  = {4'd0, coin1} + (coin5 ? 5'd5 : 5'd0) + (coin10 ? 5'd10 : 5'd0);
    assign money_sum = {1'b0, money} + {4'd0, coin_sum};
    assign coin_any  = coin1 | coin5 | coin10;
    // All coins of one cycle are accepted or refused together.
    assign coin_fits = (money_sum <= {1'b0, MONEY_MAX});
    assign money_upd = coin_fits ? money_sum[7:0] : money;
    assign sel_ok    = sel_valid && (type_in >= 3'd1) && (type_in <= 3'd4) &&
                       (count_in != 3'd0) && (count_in <= MAX_COUNT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q         <= StIdle;
            money        <= 8'd0;
            moneyReturn  <= 8'd0;
            ticketType   <= 3'd0;
            ticketCount  <= 3'd0;
            ticket_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            disp_cnt_q   <= 3'd0;
            hold_cnt_q   <= 32'd0;
        end else begin
            ticket_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            case (st_q)
                StIdle: begin
                    money       <= 8'd0;
                    moneyReturn <= 8'd0;
                    coin_reject <= coin_any;
                    if (sel_ok) begin
                        ticketType  <= type_in;
                        ticketCount <= count_in;
                        st_q        <= StPay;
                    end
                end
                StPay: begin
                    if (cancel) begin
                        // Cancel wins: coins this cycle are refused, confirm dropped.
                        moneyReturn <= money;
                        ticketCount <= 3'd0;
                        coin_reject <= coin_any;
                        hold_cnt_q  <= 32'd0;
                        st_q        <= StDone;
                    end else begin
                        coin_reject <= coin_any && !coin_fits;
                        money       <= money_upd;
                        // Same-cycle coins count towards the confirm check.
                        if (confirm && (money_upd >= total)) begin
                            disp_cnt_q <= ticketCount;
                            st_q       <= StDispense;
                        end
                    end
                end
                StDispense: begin
                    coin_reject <= coin_any;
                    if (disp_cnt_q != 3'd0) begin
                        ticket_pulse <= 1'b1;
                        disp_cnt_q   <= disp_cnt_q - 3'd1;
                    end else begin
                        moneyReturn <= money - total;
                        hold_cnt_q  <= 32'd0;
                        st_q        <= StDone;
                    end
                end
                StDone: begin
                    coin_reject <= coin_any;
                    if (hold_cnt_q >= HOLD_CYCLES - 32'd1) begin
                        money       <= 8'd0;
                        moneyReturn <= 8'd0;
                        ticketType  <= 3'd0;
                        ticketCount <= 3'd0;
                        st_q        <= StIdle;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 32'd1;
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ticket_sale_ctrl.sv
// Directed bench for ticket_sale_ctrl. Expected transaction results are
// queued when confirm/cancel is driven and popped once the DUT reaches DONE.
module tb_ticket_sale_ctrl;

    localparam logic [31:0] HOLD = 32'd16;

    logic       clk;
    logic       rst;
    logic [2:0] type_in;
    logic [2:0] count_in;
    logic       sel_valid;
    logic       coin1;
    logic       coin5;
    logic       coin10;
    logic       confirm;
    logic       cancel;
    logic [7:0] money;
    logic [7:0] moneyReturn;
    logic [2:0] ticketType;
    logic [2:0] ticketCount;
    logic       ticket_pulse;
    logic       coin_reject;
    logic       busy;
    logic [2:0] state;

    ticket_sale_ctrl #(
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .type_in     (type_in),
        .count_in    (count_in),
        .sel_valid   (sel_valid),
        .coin1       (coin1),
        .coin5       (coin5),
        .coin10      (coin10),
        .confirm     (confirm),
        .cancel      (cancel),
        .money       (money),
        .moneyReturn (moneyReturn),
        .ticketType  (ticketType),
        .ticketCount (ticketCount),
        .ticket_pulse(ticket_pulse),
        .coin_reject (coin_reject),
        .busy        (busy),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    ret;
        int    cnt;
        int    pulses;
        string tag;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sel(input int t, input int c);
        type_in   = t[2:0];
        count_in  = c[2:0];
        sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic coin(input bit c1, input bit c5, input bit c10);
        coin1  = c1;
        coin5  = c5;
        coin10 = c10;
        tick();
        coin1  = 1'b0;
        coin5  = 1'b0;
        coin10 = 1'b0;
    endtask

    task automatic push(input int ret, input int cnt, input int pulses, input string tag);
        exp_t e;
        e.ret    = ret;
        e.cnt    = cnt;
        e.pulses = pulses;
        e.tag    = tag;
        sbq.push_back(e);
    endtask

    // Run until DONE, counting pulses and separate pulse runs, then score.
    task automatic wait_done();
        exp_t e;
        int   np;
        int   runs;
        int   n;
        bit   prev;
        np   = 0;
        runs = 0;
        n    = 0;
        prev = 1'b0;
        while (state != 3'd3 && n < 100) begin
            tick();
            n++;
            if (ticket_pulse) begin
                np++;
                if (!prev) runs++;
            end
            prev = ticket_pulse;
        end
        e = sbq.pop_front();
        chk({e.tag, "_reach_done"}, int'(state), 3);
        chk({e.tag, "_return"}, int'(moneyReturn), e.ret);
        chk({e.tag, "_count"}, int'(ticketCount), e.cnt);
        chk({e.tag, "_pulses"}, np, e.pulses);
        chk({e.tag, "_pulse_runs"}, runs, (e.pulses > 0) ? 1 : 0);
    endtask

    // DONE must last HOLD cycles, then everything clears.
    task automatic wait_idle(input string tag);
        int n;
        n = 1;
        while (state == 3'd3 && n < 200) begin
            tick();
            if (state == 3'd3) n++;
        end
        chk({tag, "_hold_len"}, n, int'(HOLD));
        chk({tag, "_idle_state"}, int'(state), 0);
        chk({tag, "_idle_busy"}, int'(busy), 0);
        chk({tag, "_idle_money"}, int'(money), 0);
        chk({tag, "_idle_return"}, int'(moneyReturn), 0);
        chk({tag, "_idle_type"}, int'(ticketType), 0);
        chk({tag, "_idle_count"}, int'(ticketCount), 0);
    endtask

    initial begin
        rst       = 1'b0;
        type_in   = 3'd0;
        count_in  = 3'd0;
        sel_valid = 1'b0;
        coin1     = 1'b0;
        coin5     = 1'b0;
        coin10    = 1'b0;
        confirm   = 1'b0;
        cancel    = 1'b0;

        // Reset, with a coin present to show reset suppresses coin_reject.
        coin1 = 1'b1;
        tick();
        tick();
        coin1 = 1'b0;
        chk("rst_state", int'(state), 0);
        chk("rst_money", int'(money), 0);
        chk("rst_return", int'(moneyReturn), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulse", int'(ticket_pulse), 0);
        chk("rst_reject", int'(coin_reject), 0);
        rst = 1'b1;
        tick();

        // Normal purchase: type 2 x3 = 9, pay 10, change 1.
        sel(2, 3);
        chk("norm_state_pay", int'(state), 1);
        chk("norm_type", int'(ticketType), 2);
        chk("norm_count", int'(ticketCount), 3);
        coin(1'b0, 1'b0, 1'b1);
        chk("norm_money", int'(money), 10);
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        chk("norm_state_disp", int'(state), 2);
        push(1, 3, 3, "norm");
        wait_done();
        wait_idle("norm");

        // Insufficient funds: type 4 x4 = 20.
        sel(4, 4);
        coin(1'b0, 1'b0, 1'b1);
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        chk("insuf_state_pay", int'(state), 1);
        chk("insuf_money10", int'(money), 10);
        coin10  = 1'b1;
        confirm = 1'b1;
        tick();
        coin10  = 1'b0;
        confirm = 1'b0;
        chk("insuf_money20", int'(money), 20);
        chk("insuf_state_disp", int'(state), 2);
        push(0, 4, 4, "insuf");
        wait_done();
        wait_idle("insuf");

        // Cancel beats confirm in the same cycle.
        sel(1, 1);
        coin(1'b0, 1'b1, 1'b0);
        coin(1'b0, 1'b1, 1'b0);
        chk("cancel_money", int'(money), 10);
        cancel  = 1'b1;
        confirm = 1'b1;
        tick();
        cancel  = 1'b0;
        confirm = 1'b0;
        push(10, 0, 0, "cancel");
        wait_done();
        wait_idle("cancel");

        // Saturation at 99.
        sel(1, 1);
        for (int i = 0; i < 9; i++) coin(1'b0, 1'b0, 1'b1);
        chk("sat_money90", int'(money), 90);
        chk("sat_no_reject", int'(coin_reject), 0);
        coin(1'b0, 1'b0, 1'b1);
        chk("sat_reject10", int'(coin_reject), 1);
        chk("sat_money_hold90", int'(money), 90);
        tick();
        chk("sat_reject_clears", int'(coin_reject), 0);
        coin(1'b1, 1'b0, 1'b0);
        coin(1'b0, 1'b1, 1'b0);
        coin(1'b1, 1'b0, 1'b0);
        chk("sat_money97", int'(money), 97);
        coin(1'b0, 1'b1, 1'b0);
        chk("sat_reject5", int'(coin_reject), 1);
        chk("sat_money_hold97", int'(money), 97);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        push(97, 0, 0, "sat");
        wait_done();
        wait_idle("sat");

        // Invalid selections are ignored; coins in idle are rejected.
        sel(0, 2);
        chk("inv_t0_state", int'(state), 0);
        sel(5, 1);
        chk("inv_t5_state", int'(state), 0);
        sel(3, 0);
        chk("inv_c0_state", int'(state), 0);
        chk("inv_busy", int'(busy), 0);
        coin(1'b1, 1'b0, 1'b0);
        chk("idle_reject", int'(coin_reject), 1);
        chk("idle_money", int'(money), 0);

        // Reset during PAY with money 15.
        sel(3, 2);
        coin(1'b0, 1'b1, 1'b1);
        chk("rstpay_money", int'(money), 15);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rstpay_state", int'(state), 0);
        chk("rstpay_money0", int'(money), 0);
        chk("rstpay_type0", int'(ticketType), 0);

        // Reset mid-DISPENSE after the first pulse.
        sel(1, 2);
        coin(1'b0, 1'b1, 1'b0);
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        chk("rstdisp_state", int'(state), 2);
        tick();
        chk("rstdisp_first_pulse", int'(ticket_pulse), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rstdisp_state0", int'(state), 0);
        chk("rstdisp_pulse0", int'(ticket_pulse), 0);
        chk("rstdisp_count0", int'(ticketCount), 0);
        begin
            int np;
            np = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (ticket_pulse) np++;
            end
            chk("rstdisp_no_more_pulses", np, 0);
            chk("rstdisp_still_idle", int'(state), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
